// File: rtl/keypad_cursor_ctrl_pkg.sv
// rtl/keypad_cursor_ctrl_pkg.sv - grid constants, FSM/direction enums and one-hot key mapping
package keypad_cursor_ctrl_pkg;

  localparam int NUM_KEYS  = 26;
  localparam int COLS      = 5;
  localparam int POS_RESET = 20;
  localparam int POS_EXTRA = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_t;

  // Encoding doubles as the button index and the step priority order.
  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  function automatic logic [4:0] onehot_bit(input logic [4:0] pos);
    logic [4:0] b;
    b = 5'd0;
    case (pos)
      5'd20: b = 5'd0;
      5'd21: b = 5'd1;
      5'd22: b = 5'd2;
      5'd23: b = 5'd3;
      5'd15: b = 5'd4;
      5'd16: b = 5'd5;
      5'd17: b = 5'd6;
      5'd18: b = 5'd7;
      5'd10: b = 5'd8;
      5'd11: b = 5'd9;
      5'd12: b = 5'd10;
      5'd13: b = 5'd11;
      5'd5:  b = 5'd12;
      5'd6:  b = 5'd13;
      5'd7:  b = 5'd14;
      5'd8:  b = 5'd15;
      5'd25: b = 5'd16;
      5'd9:  b = 5'd17;
      5'd2:  b = 5'd18;
      5'd3:  b = 5'd19;
      5'd0:  b = 5'd20;
      5'd1:  b = 5'd21;
      5'd19: b = 5'd22;
      5'd14: b = 5'd23;
      5'd24: b = 5'd24;
      5'd4:  b = 5'd25;
      default: b = 5'd0;
    endcase
    return b;
  endfunction

  function automatic logic [NUM_KEYS-1:0] onehot_vec(input logic [4:0] pos);
    logic [NUM_KEYS-1:0] v;
    v = '0;
    v[onehot_bit(pos)] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/keypad_cursor_ctrl_btn_sync_edge.sv
// rtl/keypad_cursor_ctrl_btn_sync_edge.sv - 2-flop synchronizer with rising-edge detect
module btn_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic [2:0] r_fill;

  // r_fill marks when r_prev holds a real pin sample, so a button held
  // through reset release is not mistaken for a fresh press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_fill  <= 3'b000;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_fill  <= {r_fill[1:0], 1'b1};
    end
  end

  assign o_level = r_sync2;
  assign o_rise  = r_fill[2] & r_sync2 & ~r_prev;

endmodule

// File: rtl/keypad_cursor_ctrl.sv
// rtl/keypad_cursor_ctrl.sv - keypad cursor navigation with hold auto-repeat and key select strobe
module keypad_cursor_ctrl
  import keypad_cursor_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_btn_up,
  input  logic                i_btn_down,
  input  logic                i_btn_left,
  input  logic                i_btn_right,
  input  logic                i_btn_ok,
  output logic [4:0]          o_pos,
  output logic                o_key_valid,
  output logic [4:0]          o_key_code,
  output logic [NUM_KEYS-1:0] o_key_onehot
);

  localparam logic [24:0] DELAY_M1 = 25'(REPEAT_DELAY - 1);
  localparam logic [24:0] RATE_M1  = 25'(REPEAT_RATE - 1);

  function automatic logic [4:0] next_pos(input logic [4:0] p, input dir_t d);
    logic [2:0] row;
    logic [2:0] col;
    logic [4:0] np;
    row = 3'(p / 5'(COLS));
    col = 3'(p % 5'(COLS));
    np  = p;
    if (p == 5'(POS_EXTRA)) begin
      case (d)
        DIR_UP:   np = 5'd20;
        DIR_DOWN: np = 5'd0;
        default:  np = p;
      endcase
    end else begin
      case (d)
        DIR_RIGHT: np = (col == 3'd4) ? p - 5'd4 : p + 5'd1;
        DIR_LEFT:  np = (col == 3'd0) ? p + 5'd4 : p - 5'd1;
        DIR_DOWN:  np = (row == 3'd4) ? ((col == 3'd0) ? 5'(POS_EXTRA) : {2'b00, col})
                                      : p + 5'd5;
        DIR_UP:    np = (row == 3'd0) ? ((col == 3'd0) ? 5'(POS_EXTRA) : 5'd20 + {2'b00, col})
                                      : p - 5'd5;
        default:   np = p;
      endcase
    end
    return np;
  endfunction

  logic [3:0] w_btn;
  logic [3:0] w_level;
  logic [3:0] w_rise;
  logic       w_ok_level;
  logic       w_ok_rise;

  assign w_btn = {i_btn_right, i_btn_left, i_btn_down, i_btn_up};

  for (genvar g = 0; g < 4; g++) begin : g_dir_sync
    btn_sync_edge u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_btn   (w_btn[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  btn_sync_edge u_ok_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_ok),
    .o_level (w_ok_level),
    .o_rise  (w_ok_rise)
  );

  state_t              r_state;
  state_t              w_state_nxt;
  dir_t                r_dir;
  dir_t                w_dir_nxt;
  dir_t                w_step_dir;
  logic                w_step;
  logic [24:0]         r_cnt;
  logic [24:0]         w_cnt_nxt;
  logic [4:0]          r_pos;
  logic                r_key_valid;
  logic [4:0]          r_key_code;
  logic [NUM_KEYS-1:0] r_key_onehot;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_UP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_step      = 1'b0;
    w_step_dir  = r_dir;
    case (r_state)
      ST_IDLE: begin
        if (|w_rise) begin
          if (w_rise[DIR_UP])        w_step_dir = DIR_UP;
          else if (w_rise[DIR_DOWN]) w_step_dir = DIR_DOWN;
          else if (w_rise[DIR_LEFT]) w_step_dir = DIR_LEFT;
          else                       w_step_dir = DIR_RIGHT;
          w_step      = 1'b1;
          w_dir_nxt   = w_step_dir;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!w_level[r_dir]) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == DELAY_M1) begin
          w_step      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REPEAT;
        end else begin
          w_cnt_nxt = r_cnt + 25'd1;
        end
      end
      ST_REPEAT: begin
        if (!w_level[r_dir]) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == RATE_M1) begin
          w_step    = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 25'd1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The select strobe samples r_pos before any same-cycle step lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos        <= 5'(POS_RESET);
      r_key_valid  <= 1'b0;
      r_key_code   <= '0;
      r_key_onehot <= '0;
    end else begin
      if (w_step) begin
        r_pos <= next_pos(r_pos, w_step_dir);
      end
      r_key_valid  <= w_ok_rise;
      r_key_code   <= w_ok_rise ? r_pos : 5'd0;
      r_key_onehot <= w_ok_rise ? onehot_vec(r_pos) : '0;
    end
  end

  assign o_pos        = r_pos;
  assign o_key_valid  = r_key_valid;
  assign o_key_code   = r_key_code;
  assign o_key_onehot = r_key_onehot;

endmodule

// File: tb/tb_keypad_cursor_ctrl.sv
// tb/tb_keypad_cursor_ctrl.sv - randomized and directed bench for keypad_cursor_ctrl against a grid model
module tb_keypad_cursor_ctrl;

  localparam int RD = 8;
  localparam int RR = 4;
  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_OK = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  pins = 5'd0;
  logic [4:0]  pos;
  logic        key_valid;
  logic [4:0]  key_code;
  logic [25:0] key_onehot;

  always #5 clk = ~clk;

  keypad_cursor_ctrl #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_btn_up     (pins[B_UP]),
    .i_btn_down   (pins[B_DOWN]),
    .i_btn_left   (pins[B_LEFT]),
    .i_btn_right  (pins[B_RIGHT]),
    .i_btn_ok     (pins[B_OK]),
    .o_pos        (pos),
    .o_key_valid  (key_valid),
    .o_key_code   (key_code),
    .o_key_onehot (key_onehot)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  int oh_bit [26];
  initial begin
    for (int r = 1; r <= 4; r++)
      for (int c = 0; c < 4; c++)
        oh_bit[r*5+c] = (4 - r) * 4 + c;
    oh_bit[25] = 16; oh_bit[9] = 17; oh_bit[2] = 18; oh_bit[3] = 19; oh_bit[0] = 20;
    oh_bit[1] = 21; oh_bit[19] = 22; oh_bit[14] = 23; oh_bit[24] = 24; oh_bit[4] = 25;
  end

  // Grid move by row/col, with row 5 standing for the lone extra key.
  function automatic int mv(input int p, input int d);
    int r, c;
    r = (p == 25) ? 5 : p / 5;
    c = (p == 25) ? 0 : p % 5;
    case (d)
      B_UP:    r = (r == 5) ? 4 : (r == 0) ? ((c == 0) ? 5 : 4) : r - 1;
      B_DOWN:  r = (r == 5) ? 0 : (r == 4) ? ((c == 0) ? 5 : 0) : r + 1;
      B_LEFT:  if (r != 5) c = (c + 4) % 5;
      default: if (r != 5) c = (c + 1) % 5;
    endcase
    return (r == 5) ? 25 : r * 5 + c;
  endfunction

  int          m_pos, m_mode, m_dir, m_len, n;
  logic [4:0]  ph1, ph2, ph3, ph4, s_v, r_v;
  int          e_kv, e_code;
  logic [31:0] e_oh;
  int          kv_count, last_code;
  logic [31:0] last_oh;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 20; m_mode = 0; m_dir = 0; m_len = 0; n = 0;
      ph1 = 0; ph2 = 0; ph3 = 0; ph4 = 0;
    end else begin
      n++;
      ph4 = ph3; ph3 = ph2; ph2 = ph1; ph1 = pins;
      s_v = (n >= 3) ? ph3 : 5'd0;
      r_v = (n >= 4) ? (ph3 & ~ph4) : 5'd0;
      e_kv   = int'(r_v[B_OK]);
      e_code = m_pos;
      e_oh   = e_kv ? (32'd1 << oh_bit[m_pos]) : 32'd0;
      if (m_mode == 0) begin
        if (r_v[3:0] != 4'd0) begin
          m_dir = r_v[B_UP] ? B_UP : r_v[B_DOWN] ? B_DOWN : r_v[B_LEFT] ? B_LEFT : B_RIGHT;
          m_pos = mv(m_pos, m_dir);
          m_mode = 1;
          m_len = 0;
        end
      end else if (!s_v[m_dir]) begin
        m_mode = 0;
      end else begin
        m_len++;
        if (m_len == RD || (m_len > RD && (m_len - RD) % RR == 0))
          m_pos = mv(m_pos, m_dir);
      end
      #1;
      if (rst_n) begin
        check("pos", 32'(pos), 32'(m_pos));
        check("key_valid", 32'(key_valid), 32'(e_kv));
        check("key_onehot", 32'(key_onehot), e_oh);
        if (e_kv != 0) check("key_code", 32'(key_code), 32'(e_code));
        if (key_valid) begin
          kv_count++;
          last_code = key_code;
          last_oh = 32'(key_onehot);
        end
      end
    end
  end

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic press(input int b, input int hold);
    pins[b] = 1'b1;
    idle(hold);
    pins[b] = 1'b0;
    idle(4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pins = 5'd0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit found;
    idle(3);
    check("rst_pos", 32'(pos), 32'd20);
    check("rst_kv", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_onehot", 32'(key_onehot), 32'd0);
    rst_n = 1'b1;
    idle(2);

    press(B_UP, 2); press(B_UP, 2); press(B_LEFT, 2);
    check("seq_up_up_left", 32'(pos), 32'd14);

    do_reset();
    repeat (4) press(B_UP, 2);
    check("to_zero", 32'(pos), 32'd0);
    press(B_UP, 2);
    check("zero_up_extra", 32'(pos), 32'd25);
    press(B_DOWN, 2);
    check("extra_down_zero", 32'(pos), 32'd0);
    repeat (5) press(B_RIGHT, 2);
    check("right_wrap5", 32'(pos), 32'd0);

    do_reset();
    pins[B_RIGHT] = 1'b1;
    idle(23);
    check("hold_right_end", 32'(pos), 32'd20);
    pins[B_RIGHT] = 1'b0;
    idle(10);
    check("hold_release", 32'(pos), 32'd20);

    do_reset();
    press(B_UP, 2); press(B_UP, 2); press(B_RIGHT, 2); press(B_RIGHT, 2);
    check("at_12", 32'(pos), 32'd12);
    kv_count = 0;
    press(B_OK, 10);
    check("ok_pulses", 32'(kv_count), 32'd1);
    check("ok_code", 32'(last_code), 32'd12);
    check("ok_onehot", last_oh, 32'd1 << 10);

    press(B_UP, 2);
    check("at_7", 32'(pos), 32'd7);
    kv_count = 0;
    pins = 5'b10101;
    idle(3);
    pins = 5'd0;
    idle(5);
    check("prio_pos", 32'(pos), 32'd2);
    check("prio_code", 32'(last_code), 32'd7);
    check("prio_pulses", 32'(kv_count), 32'd1);

    do_reset();
    pins[B_RIGHT] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (pos == 5'd23) found = 1'b1;
    end
    check("reach_23", 32'(found), 32'd1);
    idle(1);
    pins[B_DOWN] = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("async_rst_pos", 32'(pos), 32'd20);
    check("async_rst_kv", 32'(key_valid), 32'd0);
    pins[B_RIGHT] = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(10);
    check("held_down_no_step", 32'(pos), 32'd20);
    pins = 5'd0;
    idle(5);
    check("down_release_no_step", 32'(pos), 32'd20);

    do_reset();
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 11) == 0) pins[b] = ~pins[b];
      if ($urandom_range(0, 60) == 0) pins = 5'd0;
    end
    pins = 5'd0;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
